// File: rtl/processor_pkg.sv
// Shared definitions for the 10-bit processor: timesteps, opcodes, prefixes, word type.
package processor_pkg;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [3:0] LD  = 4'd0;
  localparam logic [3:0] CP  = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] SUB = 4'd3;
  localparam logic [3:0] INV = 4'd4;
  localparam logic [3:0] FLP = 4'd5;
  localparam logic [3:0] AND = 4'd6;
  localparam logic [3:0] OR  = 4'd7;
  localparam logic [3:0] XOR = 4'd8;
  localparam logic [3:0] LSL = 4'd9;
  localparam logic [3:0] LSR = 4'd10;
  localparam logic [3:0] ASR = 4'd11;

  localparam logic [1:0] PFX_ALU  = 2'b00;
  localparam logic [1:0] PFX_ADDI = 2'b10;
  localparam logic [1:0] PFX_SUBI = 2'b11;

  typedef logic [9:0] word_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces an active-low pushbutton; emits one pulse per accepted press.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            acc_q, acc_d;
  logic            acc_prev_q, acc_prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  // Debounce counter, accepted level and falling-edge pulse next-state.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      acc_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    acc_prev_d = acc_q;
    // Pulse one cycle after the accepted level falls (press); release is ignored.
    pulse_d    = acc_prev_q & ~acc_q;
  end

  // State update with synchronous active-low reset; button reads as released after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      acc_q      <= 1'b1;
      acc_prev_q <= 1'b1;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_n;
      sync2_q    <= sync1_q;
      acc_q      <= acc_d;
      acc_prev_q <= acc_prev_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Front end of the processor: step generation, timestep counter, IR and retirement count.
module instruction_sequencer
  import processor_pkg::*;
#(
  parameter int unsigned DATA_W          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enter_n,
  input  logic              IRin,
  input  logic              Clr,
  output logic [DATA_W-1:0] INST,
  output logic [1:0]        T,
  output logic              step,
  output logic [CNT_W-1:0]  instr_count
);

  logic [1:0]        t_q, t_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic              step_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (enter_n),
    .press_pulse(step_pulse)
  );

  // Controller handshakes are only meaningful on step cycles.
  always_comb begin
    t_d           = t_q;
    inst_d        = inst_q;
    instr_count_d = instr_count_q;
    if (step_pulse) begin
      t_d = Clr ? T0 : t_q + 2'd1;
      if (IRin) begin
        inst_d = data_in;
      end
      if ((Clr || (t_q == T3)) && (instr_count_q != {CNT_W{1'b1}})) begin
        instr_count_d = instr_count_q + CNT_W'(1);
      end
    end
  end

  // Registered sequencer state; reset wins over any step in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q           <= T0;
      inst_q        <= '0;
      instr_count_q <= '0;
    end else begin
      t_q           <= t_d;
      inst_q        <= inst_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign T           = t_q;
  assign INST        = inst_q;
  assign instr_count = instr_count_q;
  assign step        = step_pulse;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer.
module tb_instruction_sequencer;

  logic       clk;
  logic       rst_n;
  logic [9:0] data_in;
  logic       enter_n;
  logic       IRin;
  logic       Clr;
  logic [9:0] INST;
  logic [1:0] T;
  logic       step;
  logic [7:0] instr_count;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int step_seen = 0;

  instruction_sequencer #(
    .DATA_W         (10),
    .DEBOUNCE_CYCLES(16),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .enter_n    (enter_n),
    .IRin       (IRin),
    .Clr        (Clr),
    .INST       (INST),
    .T          (T),
    .step       (step),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count step pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (step === 1'b1) step_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Clean press held long enough to be accepted, then a clean release.
  task automatic press(input logic irin_v, input logic clr_v);
    IRin    = irin_v;
    Clr     = clr_v;
    enter_n = 1'b0;
    repeat (22) @(negedge clk);
    enter_n = 1'b1;
    repeat (22) @(negedge clk);
    IRin = 1'b0;
    Clr  = 1'b0;
  endtask

  int         lat;
  int         s0;
  logic [7:0] exp_cnt;

  initial begin
    rst_n   = 1'b1;
    data_in = 10'h3FF;
    enter_n = 1'b1;
    IRin    = 1'b0;
    Clr     = 1'b0;
    @(negedge clk);

    // 1: reset with bouncing button
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      enter_n = ~enter_n;
      @(negedge clk);
    end
    rst_n   = 1'b1;
    enter_n = 1'b1;
    check_eq("rst_T", T, 0);
    check_eq("rst_INST", INST, 0);
    check_eq("rst_cnt", instr_count, 0);
    check_eq("rst_step", step, 0);
    repeat (25) @(negedge clk);
    check_eq("rst_no_step", step_seen, 0);

    // 2: clean press, latency measurement
    data_in = 10'b00_01_10_0010;
    IRin    = 1'b1;
    Clr     = 1'b0;
    s0      = step_seen;
    enter_n = 1'b0;
    lat     = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (step === 1'b1) break;
    end
    check_eq("press_latency", lat, 19);
    repeat (40 - lat) @(negedge clk);
    enter_n = 1'b1;
    repeat (30) @(negedge clk);
    IRin = 1'b0;
    check_eq("press_one_step", step_seen - s0, 1);
    check_eq("press_INST", INST, 10'h062);
    check_eq("press_T", T, 1);

    // 3: bounce rejection
    data_in = 10'h155;
    IRin    = 1'b1;
    s0      = step_seen;
    for (int k = 0; k < 3; k++) begin
      enter_n = 1'b0;
      repeat (5) @(negedge clk);
      enter_n = 1'b1;
      repeat (5) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    IRin = 1'b0;
    check_eq("bounce_no_step", step_seen - s0, 0);
    check_eq("bounce_T", T, 1);
    check_eq("bounce_INST", INST, 10'h062);

    // 4: four-step ALU instruction from a fresh state
    do_reset();
    data_in = 10'b00_0010_0110;
    press(1'b1, 1'b0);
    check_eq("alu_T1", T, 1);
    check_eq("alu_INST", INST, 10'h026);
    data_in = 10'h2AA;
    press(1'b0, 1'b0);
    check_eq("alu_T2", T, 2);
    press(1'b0, 1'b0);
    check_eq("alu_T3", T, 3);
    check_eq("alu_cnt_pre", instr_count, 0);
    press(1'b0, 1'b1);
    check_eq("alu_T0", T, 0);
    check_eq("alu_cnt", instr_count, 1);
    check_eq("alu_INST_hold", INST, 10'h026);

    // 5: early clear at T1, then Clr at T0
    data_in = 10'h001;
    press(1'b1, 1'b0);
    check_eq("ld_T1", T, 1);
    press(1'b0, 1'b1);
    check_eq("ld_clr_T", T, 0);
    check_eq("ld_clr_cnt", instr_count, 2);
    press(1'b0, 1'b1);
    check_eq("clr_T0_T", T, 0);
    check_eq("clr_T0_cnt", instr_count, 3);

    // 6: saturation
    exp_cnt = 8'd3;
    while (exp_cnt != 8'd255) begin
      press(1'b0, 1'b1);
      exp_cnt++;
    end
    check_eq("sat_reach", instr_count, 255);
    press(1'b0, 1'b1);
    check_eq("sat_hold", instr_count, 255);
    check_eq("sat_T", T, 0);

    // Mid-instruction reset with a press in progress
    data_in = 10'h3C3;
    press(1'b1, 1'b0);
    press(1'b0, 1'b0);
    check_eq("mid_T2", T, 2);
    check_eq("mid_INST", INST, 10'h3C3);
    s0      = step_seen;
    enter_n = 1'b0;
    repeat (10) @(negedge clk);
    do_reset();
    enter_n = 1'b1;
    check_eq("mid_rst_T", T, 0);
    check_eq("mid_rst_INST", INST, 0);
    check_eq("mid_rst_cnt", instr_count, 0);
    repeat (30) @(negedge clk);
    check_eq("mid_rst_no_step", step_seen - s0, 0);
    check_eq("mid_rst_T_hold", T, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
